// File: rtl/niosii_pio_out.sv
// Avalon-MM output PIO: data register on out_port with bit set/clear offsets
// and a per-bit pulse engine that auto-clears masked bits after pulse_len clocks.
module niosii_pio_out #(
   parameter int unsigned      WIDTH         = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
   parameter logic [15:0]      PULSE_DEFAULT = 16'd1000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [WIDTH-1:0] data;
   logic [WIDTH-1:0] pulse_mask;
   logic [15:0]      pulse_len;
   logic [15:0]      counter;

   logic             wr;
   logic             data_wr;
   logic             trigger;
   logic             expire;
   logic             busy;
   logic [WIDTH-1:0] wr_val;
   logic [WIDTH-1:0] new_data;
   logic [15:0]      len_eff;
   logic [31:0]      rd_mux;
   logic             unused_ok;

   assign unused_ok = ^writedata;
   assign out_port  = data;
   assign busy      = (state == RUN);

   always_comb begin
      wr       = chipselect & ~write_n;
      wr_val   = writedata[WIDTH-1:0];
      new_data = data;
      case (address)
         3'd0:    new_data = wr_val;
         3'd4:    new_data = data | wr_val;
         3'd5:    new_data = data & ~wr_val;
         default: new_data = data;
      endcase
      data_wr = wr && (address == 3'd0 || address == 3'd4 || address == 3'd5);
      // only a rising masked bit starts (or restarts) a pulse
      trigger = wr && (address == 3'd0 || address == 3'd4)
                   && (|(new_data & ~data & pulse_mask));
      // a CPU data write in the final cycle wins over the auto-clear
      expire  = busy && (counter == 16'd1) && !data_wr;
      len_eff = (pulse_len == 16'd0) ? 16'd1 : pulse_len;
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         3'd0:    rd_mux = 32'(data);
         3'd1:    rd_mux = 32'(pulse_mask);
         3'd2:    rd_mux = 32'(pulse_len);
         3'd3:    rd_mux = 32'(busy);
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data       <= RESET_VALUE;
         pulse_mask <= '0;
         pulse_len  <= PULSE_DEFAULT;
         counter    <= '0;
         state      <= IDLE;
         readdata   <= '0;
      end else begin
         readdata <= rd_mux;

         if (data_wr)     data <= new_data;
         else if (expire) data <= data & ~pulse_mask;

         if (wr && address == 3'd1) pulse_mask <= wr_val;
         if (wr && address == 3'd2) pulse_len  <= writedata[15:0];

         if (trigger) begin
            counter <= len_eff;
            state   <= RUN;
         end else begin
            case (state)
               IDLE: counter <= '0;
               RUN: begin
                  if (counter == 16'd1) begin
                     counter <= '0;
                     state   <= IDLE;
                  end else begin
                     counter <= counter - 16'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_niosii_pio_out.sv
// Scoreboard bench for niosii_pio_out: stimulus queues expectations tagged with
// the cycle they are due; a negedge monitor pops and compares them.
module tb_niosii_pio_out;

   localparam int W = 8;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [2:0]    address;
   logic          chipselect;
   logic          write_n;
   logic [31:0]   writedata;
   logic [31:0]   readdata;
   logic [W-1:0]  out_port;

   niosii_pio_out #(.WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      int          due;
      bit          rd;
      logic [31:0] exp;
      string       name;
   } item_t;

   item_t sb[$];
   int    checks = 0;
   int    errors = 0;

   task automatic push(input int due, input bit rd, input logic [31:0] exp, input string name);
      item_t it;
      it.due = due; it.rd = rd; it.exp = exp; it.name = name;
      sb.push_back(it);
   endtask

   // out_port expectation for the current cycle (sampled at this cycle's negedge)
   task automatic exp_out(input logic [31:0] v, input string name);
      push(cyc, 1'b0, v, name);
   endtask

   // all tasks start and end 1 time unit after a rising edge
   task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic bus_rd(input logic [2:0] a, input logic [31:0] exp, input string name);
      chipselect = 1'b1; write_n = 1'b1; address = a;
      push(cyc + 1, 1'b1, exp, name);
      @(posedge clk); #1;
      chipselect = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // called right after a triggering write: out_port holds hi for n_hi cycles, then lo
   task automatic watch(input int n_hi, input logic [31:0] hi, input logic [31:0] lo, input string name);
      for (int k = 0; k <= n_hi + 1; k++) begin
         exp_out((k < n_hi) ? hi : lo, name);
         bus_rd(3'd3, (k < n_hi) ? 32'd1 : 32'd0, {name, "_busy"});
      end
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         item_t it;
         logic [31:0] act;
         it  = sb.pop_front();
         act = it.rd ? readdata : 32'(out_port);
         checks++;
         if (it.due != cyc || act !== it.exp) begin
            errors++;
            $display("FAIL %s: %s got %h expected %h (cycle %0d due %0d)",
                     it.name, it.rd ? "readdata" : "out_port", act, it.exp, cyc, it.due);
         end
      end
   end

   initial begin
      reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
      idle(3);
      exp_out(32'h00, "reset_out");
      push(cyc, 1'b1, 32'h0, "reset_rd");
      reset_n = 1'b1;
      bus_rd(3'd2, 32'd1000, "reset_len");
      bus_rd(3'd1, 32'd0, "reset_mask");

      // data write and readback
      bus_wr(3'd0, 32'hFFFF_FFA5);
      exp_out(32'hA5, "data_out");
      bus_rd(3'd0, 32'hA5, "data_rd");

      // set / clear and write-only / reserved offsets
      bus_wr(3'd0, 32'h0F);
      bus_wr(3'd4, 32'hF0);
      exp_out(32'hFF, "outset");
      bus_wr(3'd5, 32'h3C);
      exp_out(32'hC3, "outclear");
      bus_rd(3'd0, 32'hC3, "clr_rd");
      bus_rd(3'd4, 32'h0, "rd_off4");
      bus_rd(3'd5, 32'h0, "rd_off5");
      bus_wr(3'd6, 32'hFF);
      bus_wr(3'd3, 32'hFF);
      exp_out(32'hC3, "reserved_wr");
      bus_rd(3'd6, 32'h0, "rd_off6");
      bus_rd(3'd3, 32'h0, "status_idle");

      // 5-clock pulse on bit0
      bus_wr(3'd1, 32'h01);
      bus_wr(3'd2, 32'h5);
      bus_rd(3'd1, 32'h01, "mask_rd");
      bus_rd(3'd2, 32'h5, "len_rd");
      bus_wr(3'd0, 32'h00);
      bus_wr(3'd0, 32'h81);
      watch(5, 32'h81, 32'h80, "pulse5");

      // pulse_len of 0 behaves as 1
      bus_wr(3'd2, 32'h0);
      bus_wr(3'd0, 32'h81);
      watch(1, 32'h81, 32'h80, "pulse0");

      // retrigger: clear then outset at count 2 reloads a full 5 clocks
      bus_wr(3'd2, 32'h5);
      bus_wr(3'd0, 32'h81);
      exp_out(32'h81, "retrig_start");
      bus_wr(3'd5, 32'h01);
      exp_out(32'h80, "retrig_clr");
      idle(2);
      bus_wr(3'd4, 32'h01);
      watch(5, 32'h81, 32'h80, "retrig");

      // collision: data write in the expiry cycle wins and ends the pulse
      bus_wr(3'd0, 32'h81);
      exp_out(32'h81, "coll_start");
      idle(3);
      bus_rd(3'd3, 32'd1, "coll_busy_pre");
      exp_out(32'h81, "coll_last");
      bus_wr(3'd0, 32'h03);
      watch(0, 32'h0, 32'h03, "collision");

      // asynchronous reset in the middle of a pulse
      bus_wr(3'd5, 32'h01);
      bus_wr(3'd4, 32'h01);
      exp_out(32'h03, "ar_start");
      idle(1);
      #1 reset_n = 1'b0;
      exp_out(32'h00, "ar_out");
      push(cyc, 1'b1, 32'h0, "ar_rd");
      @(posedge clk); #1;
      reset_n = 1'b1;
      bus_rd(3'd3, 32'd0, "ar_busy");
      bus_rd(3'd1, 32'd0, "ar_mask");
      bus_rd(3'd2, 32'd1000, "ar_len");
      exp_out(32'h00, "ar_out_after");

      idle(2);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
